// File: rtl/dma_rd_master.sv
`timescale 1ns/1ps
// dma_rd_master: DMA read request engine. Splits one read command
// into bursts (r_req/r_ack), gathers beats (dvld/dack) into an output
// FIFO, streams them out (out_vld/out_rdy) with a whole-command last.
// Ports: clk, rst_n | cmd_vld/cmd_rdy/cmd_addr/cmd_len |
//   r_req/r_ack/r_addr/r_len | dvld/rd_last/rdata/rbe/dack |
//   out_vld/out_rdy/out_data/out_be/out_last | done, err pulses.
// Macro DMA_RD_4K_SPLIT_EN: when defined, no burst crosses 4 KB.
module dma_rd_master #(
  parameter int MAX_LEN    = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_len,
  output logic        r_req,
  input  logic        r_ack,
  output logic [31:0] r_addr,
  output logic [15:0] r_len,
  input  logic        dvld,
  input  logic        rd_last,
  input  logic [31:0] rdata,
  input  logic [3:0]  rbe,
  output logic        dack,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_data,
  output logic [3:0]  out_be,
  output logic        out_last,
  output logic        done,
  output logic        err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_cur;
  logic [31:0] r_rem;
  logic [15:0] r_exp;
  logic [15:0] r_cnt;
  logic        r_ovf;
  logic        r_done;
  logic        r_err;

  logic [36:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_fcnt;

  logic [15:0] w_lim;
  logic [15:0] w_blen;
  logic [15:0] w_exp;
  logic [15:0] w_cnt1;
  logic        w_acc;
  logic        w_ack;
  logic        w_full;
  logic        w_empty;
  logic        w_beat;
  logic        w_end;
  logic        w_last;
  logic        w_pop;
  logic [36:0] w_head;

`ifdef DMA_RD_4K_SPLIT_EN
  logic [15:0] w_bnd;
  assign w_bnd = 16'd4096 - {4'd0, r_cur[11:0]};
  assign w_lim = (w_bnd < 16'(MAX_LEN)) ? w_bnd : 16'(MAX_LEN);
`else
  assign w_lim = 16'(MAX_LEN);
`endif

  // blen never exceeds remaining, so remaining cannot underflow
  assign w_blen = (r_rem < {16'd0, w_lim}) ? r_rem[15:0] : w_lim;
  assign w_exp  = (16'd3 + {14'd0, r_cur[1:0]} + w_blen) >> 2;
  assign w_cnt1 = r_cnt + 16'd1;

  assign w_acc   = cmd_vld & cmd_rdy;
  assign w_ack   = r_req & r_ack;
  assign w_full  = (r_fcnt == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_fcnt == '0);
  assign w_beat  = dvld & dack;
  assign w_end   = w_beat & rd_last;
  assign w_last  = rd_last & (r_rem == '0);
  assign w_pop   = ~w_empty & out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc && cmd_len != '0) w_next = S_REQ;
      S_REQ:  if (r_ack) w_next = S_DATA;
      S_DATA: if (w_end) w_next = (r_rem == '0) ? S_IDLE : S_REQ;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy = 1'b0;
    r_req   = 1'b0;
    r_addr  = '0;
    r_len   = '0;
    dack    = 1'b0;
    unique case (r_state)
      S_IDLE: cmd_rdy = 1'b1;
      S_REQ: begin
        r_req  = 1'b1;
        r_addr = r_cur;
        r_len  = w_blen;
      end
      S_DATA: dack = ~w_full;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= '0;
      r_rem  <= '0;
      r_exp  <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (w_acc & (cmd_len == '0)) | (w_end & (r_rem == '0));
      // short/long burst: rd_last at wrong count, or overrun (once)
      r_err  <= (w_end & (w_cnt1 != r_exp)) |
                (w_beat & ~rd_last & (w_cnt1 > r_exp) & ~r_ovf);
      if (w_acc) begin
        r_cur <= cmd_addr;
        r_rem <= cmd_len;
      end
      if (w_ack) begin
        r_cur <= r_cur + {16'd0, w_blen};
        r_rem <= r_rem - {16'd0, w_blen};
        r_exp <= w_exp;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
      if (w_beat) begin
        if (r_cnt != '1) r_cnt <= w_cnt1;
        if (~rd_last && w_cnt1 > r_exp) r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_beat) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_beat, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) r_mem[r_wp] <= {rdata, rbe, w_last};
  end

  assign w_head   = r_mem[r_rp];
  assign out_vld  = ~w_empty;
  assign out_data = out_vld ? w_head[36:5] : '0;
  assign out_be   = out_vld ? w_head[4:1]  : '0;
  assign out_last = out_vld & w_head[0];
  assign done     = r_done;
  assign err      = r_err;

endmodule
